glb_sram_arbiter: RTL and testbench
===================================

# glb_sram_arbiter

Two-port arbiter and init sequencer for one 2048x64 single-port global-buffer SRAM macro with active-low CEB/WEB/BWEB. It zero-clears the macro after reset, then shares it between a data port (p0, tile/stream side) and a config port (p1, host side). Arbitration is round-robin with a req/gnt handshake, and each port gets its own read-valid return. It sits between the bank controller and the macro instance, and is the only block that drives the macro pins.

## Interface
- ADDR_WIDTH, 11, word address width (2**ADDR_WIDTH words)
- DATA_WIDTH, 64, word width; must be a multiple of 8
- INIT_EN, 1, 1 = zero-clear the whole array after reset; 0 = skip the clear and go straight to RUN
- clk  input  1  single clock; all state updates on its rising edge
- reset_n  input  1  synchronous, active-low reset
- pN_req  input  1  (N=0,1) request; held until granted
- pN_wen  input  1  1 = write, 0 = read
- pN_addr  input  ADDR_WIDTH  word address
- pN_wdata  input  DATA_WIDTH  write data
- pN_wstrb  input  DATA_WIDTH/8  byte enables, active-high
- pN_gnt  output  1  combinational grant; the transfer happens on the edge where pN_req && pN_gnt
- pN_rd_valid  output  1  registered; high for exactly one cycle with the read data
- rd_data  output  DATA_WIDTH  shared read data, driven straight from mem_q; qualified by pN_rd_valid
- init_done  output  1  registered; high once the clear is complete
- mem_ceb, mem_web  output  1  macro chip enable and write enable, active-low
- mem_a  output  ADDR_WIDTH  macro address
- mem_d  output  DATA_WIDTH  macro write data
- mem_bweb  output  DATA_WIDTH  macro bit write enables, active-low
- mem_q  input  DATA_WIDTH  macro read data; updates on the clk edge that performs an enabled access

## Operation
- FSM has two states, CLEAR and RUN. Reset enters CLEAR if INIT_EN=1, otherwise RUN.
- CLEAR behaviour:
  - Drives mem_ceb=0, mem_web=0, mem_bweb=0, mem_d=0 and mem_a=clr_cnt.
  - clr_cnt starts at 0 and increments every cycle.
  - On the cycle with clr_cnt=2**ADDR_WIDTH-1, that address is written, the FSM moves to RUN and init_done sets.
  - Both grants are 0 throughout CLEAR.
- RUN behaviour:
  - Only p0 requesting: grant p0. Only p1 requesting: grant p1.
  - Both requesting: grant the port that was not granted most recently (last_gnt register).
  - last_gnt resets to 1, so p0 wins the first contention.
  - last_gnt updates only on a cycle with a grant.
- Macro drive in RUN:
  - Granted cycle: mem_ceb=0 and mem_web=~wen. mem_a and mem_d come from the granted port.
  - mem_bweb byte b equals {8{~wstrb[b]}} for a write; it is all 1s for a read.
  - No grant: mem_ceb=1, mem_web=1, mem_bweb all 1s. mem_a and mem_d are don't-care and held at 0.
- Read return:
  - A granted read from port N sets pN_rd_valid in the next cycle; rd_data=mem_q in that cycle.
  - A granted write never raises rd_valid.
- A write with wstrb=0 is still an enabled access with no bits written.
- Requests from both ports to the same address are serialised in grant order. A read granted after a write to that address returns the newly written data.

## Timing
- Reset values: init_done=0, p0_rd_valid=0, p1_rd_valid=0, grants=0, mem_ceb=1, mem_web=1, mem_bweb all 1s, clr_cnt=0, last_gnt=1.
- The clear takes 2**ADDR_WIDTH cycles (2048 by default). init_done rises in the first cycle after the last clear write, and the first grant is possible in that same cycle.
- Read latency is 1 cycle from the grant edge to the valid data cycle.
- Throughput is one access per cycle. Back-to-back reads from alternating ports produce alternating rd_valid pulses with no bubbles.
- Reset asserted mid-CLEAR: the clear restarts from address 0 after release.
- Reset asserted mid-RUN:
  - A pending rd_valid is dropped and init_done clears.
  - With INIT_EN=1 the array is cleared again.
- A request deasserted before being granted is simply lost; there is no abort hazard.

## Test plan
- Reset with INIT_EN=1:
  - Response: exactly 2048 write cycles on addresses 0..2047 with mem_d=0 and mem_bweb=0.
  - Response: init_done rises on cycle 2048 after reset release.
  - Response: no grants while clearing; a p0 read of address 5 afterwards returns 0.
- p0 writes 0x0123456789ABCDEF to address 0x10 with wstrb=0xFF, then p0 reads address 0x10:
  - Response: p0_rd_valid pulses 1 cycle after the read grant with rd_data=0x0123456789ABCDEF.
  - Response: p1_rd_valid stays 0.
- Partial write:
  - Stimulus: p1 writes 0xFFFFFFFFFFFFFFFF to address 0x20 with wstrb=0x0F onto a cleared word.
  - Response: mem_bweb=0xFFFFFFFF00000000; a following read returns 0x00000000FFFFFFFF.
- Contention:
  - Stimulus: both ports hold reads for 6 cycles, p0 at address 1 and p1 at address 2.
  - Response: grants alternate p0,p1,p0,p1,p0,p1.
  - Response: rd_valid alternates the same way one cycle later, with rd_data matching each address.
- Ordering: p1 writes 0xAA to address 7 and p0 reads address 7 in the next cycle → the read returns 0xAA.
- Reset pulse at clr_cnt=1000, then release → the clear restarts at address 0 and init_done rises 2048 cycles after the release.

Source files
------------

// File: rtl/glb_sram_port_if.sv
// One requester port of the global-buffer SRAM arbiter: req/gnt handshake,
// write payload, and the per-port read return.
interface glb_sram_port_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64
);
  logic                    req;
  logic                    wen;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    gnt;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;

  modport master (
    output req, wen, addr, wdata, wstrb,
    input  gnt, rd_valid, rd_data
  );

  modport slave (
    input  req, wen, addr, wdata, wstrb,
    output gnt, rd_valid, rd_data
  );
endinterface

// File: rtl/glb_sram_arbiter.sv
// Init sequencer and two-port round-robin arbiter for a single-port
// global-buffer SRAM macro with active-low CEB/WEB/BWEB pins.
module glb_sram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  glb_sram_port_if.slave        p0,
  glb_sram_port_if.slave        p1,
  output logic                  o_init_done,
  output logic                  o_mem_ceb,
  output logic                  o_mem_web,
  output logic [ADDR_WIDTH-1:0] o_mem_a,
  output logic [DATA_WIDTH-1:0] o_mem_d,
  output logic [DATA_WIDTH-1:0] o_mem_bweb,
  input  logic [DATA_WIDTH-1:0] i_mem_q
);

  localparam int                    STRB_W    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] strb_to_bweb(
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_WIDTH-1:0] bweb;
    bweb = '1;
    for (int b = 0; b < STRB_W; b++) begin
      bweb[b*8 +: 8] = {8{~strb[b]}};
    end
    return bweb;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
  logic                  r_last_gnt;
  logic                  r_init_done;
  logic                  r_p0_rd_vld_p1;
  logic                  r_p1_rd_vld_p1;
  logic                  w_gnt0;
  logic                  w_gnt1;

  // Stage p0 -> p1: state, arbitration history and read-valid return
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= INIT_EN ? ST_CLEAR : ST_RUN;
      r_clr_cnt      <= '0;
      r_last_gnt     <= 1'b1;
      r_init_done    <= 1'b0;
      r_p0_rd_vld_p1 <= 1'b0;
      r_p1_rd_vld_p1 <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_clr_cnt      <= w_clr_cnt_nxt;
      r_init_done    <= (w_state_nxt == ST_RUN);
      r_p0_rd_vld_p1 <= w_gnt0 & ~p0.wen;
      r_p1_rd_vld_p1 <= w_gnt1 & ~p1.wen;
      if (w_gnt0) begin
        r_last_gnt <= 1'b0;
      end else if (w_gnt1) begin
        r_last_gnt <= 1'b1;
      end
    end
  end

  // The macro pins are gated by reset so the array sees no access while held.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_gnt0        = 1'b0;
    w_gnt1        = 1'b0;
    o_mem_ceb     = 1'b1;
    o_mem_web     = 1'b1;
    o_mem_a       = '0;
    o_mem_d       = '0;
    o_mem_bweb    = '1;
    if (i_reset_n) begin
      case (r_state)
        ST_CLEAR: begin
          o_mem_ceb     = 1'b0;
          o_mem_web     = 1'b0;
          o_mem_bweb    = '0;
          o_mem_a       = r_clr_cnt;
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADDR) begin
            w_state_nxt   = ST_RUN;
            w_clr_cnt_nxt = '0;
          end
        end
        ST_RUN: begin
          w_gnt0 = p0.req & (~p1.req | r_last_gnt);
          w_gnt1 = p1.req & (~p0.req | ~r_last_gnt);
          if (w_gnt0) begin
            o_mem_ceb  = 1'b0;
            o_mem_web  = ~p0.wen;
            o_mem_a    = p0.addr;
            o_mem_d    = p0.wdata;
            o_mem_bweb = p0.wen ? strb_to_bweb(p0.wstrb) : '1;
          end else if (w_gnt1) begin
            o_mem_ceb  = 1'b0;
            o_mem_web  = ~p1.wen;
            o_mem_a    = p1.addr;
            o_mem_d    = p1.wdata;
            o_mem_bweb = p1.wen ? strb_to_bweb(p1.wstrb) : '1;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  assign p0.gnt      = w_gnt0;
  assign p1.gnt      = w_gnt1;
  assign p0.rd_valid = r_p0_rd_vld_p1;
  assign p1.rd_valid = r_p1_rd_vld_p1;
  assign p0.rd_data  = i_mem_q;
  assign p1.rd_data  = i_mem_q;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_glb_sram_arbiter.sv
// Randomised scoreboard bench for glb_sram_arbiter with a behavioural SRAM macro.
module tb_glb_sram_arbiter;
  localparam int AW    = 11;
  localparam int DW    = 64;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          init_done, mem_ceb, mem_web;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d, mem_bweb, mem_q;

  always #5 clk = ~clk;

  glb_sram_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
  glb_sram_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

  glb_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .p0          (p0_if),
    .p1          (p1_if),
    .o_init_done (init_done),
    .o_mem_ceb   (mem_ceb),
    .o_mem_web   (mem_web),
    .o_mem_a     (mem_a),
    .o_mem_d     (mem_d),
    .o_mem_bweb  (mem_bweb),
    .i_mem_q     (mem_q)
  );

  // Macro model, seeded with garbage so the clear is observable.
  logic [DW-1:0] sram [DEPTH];
  bit            seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= {$urandom(), $urandom()};
      seeded <= 1'b1;
    end else if (!mem_ceb) begin
      if (!mem_web) sram[mem_a] <= (sram[mem_a] & mem_bweb) | (mem_d & ~mem_bweb);
      else          mem_q <= sram[mem_a];
    end
  end

  typedef struct {
    int          cyc;
    bit          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  function automatic logic [DW-1:0] byte_mask(input logic [SW-1:0] s);
    logic [DW-1:0] m;
    for (int b = 0; b < SW; b++) m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor and reference model: one step per clock, sampled mid-cycle.
  initial begin : monitor
    int            m_clr;
    bit            m_last, m_done, m_prev_rst;
    bit            ev0, ev1, eg0, eg1, gp, gwen;
    int            idx;
    exp_t          e;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd, gmask;
    logic [142:0]  act_pins, exp_pins;
    m_clr = 0; m_last = 1'b1; m_done = 1'b0; m_prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      act_pins = {p1_if.gnt, p0_if.gnt, mem_ceb, mem_web, mem_bweb, mem_a, mem_d};
      if (m_prev_rst) begin
        chk("reset_regs", {init_done, p1_if.rd_valid, p0_if.rd_valid}, 3'b000);
      end else begin
        ev0 = (expq.size() > 0) && (expq[0].cyc == cyc) && !expq[0].port;
        ev1 = (expq.size() > 0) && (expq[0].cyc == cyc) && expq[0].port;
        chk("rd_valid", {p1_if.rd_valid, p0_if.rd_valid}, {ev1, ev0});
        if (ev0 || ev1) begin
          e = expq.pop_front();
          if (ev0) chk("p0_rd_data", p0_if.rd_data, e.data);
          else     chk("p1_rd_data", p1_if.rd_data, e.data);
        end
        chk("init_done", init_done, m_done);
      end
      if (!reset_n) begin
        exp_pins = {2'b00, 1'b1, 1'b1, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}};
        chk("reset_pins", act_pins, exp_pins);
        m_clr = DEPTH; m_last = 1'b1; m_done = 1'b0; m_prev_rst = 1'b1;
        expq.delete();
      end else begin
        m_prev_rst = 1'b0;
        if (m_clr > 0) begin
          idx = DEPTH - m_clr;
          exp_pins = {2'b00, 1'b0, 1'b0, {DW{1'b0}}, idx[AW-1:0], {DW{1'b0}}};
          chk("clear_pins", act_pins, exp_pins);
          ref_mem[idx] = '0;
          m_clr--;
          if (m_clr == 0) m_done = 1'b1;
        end else begin
          eg0 = p0_if.req && (!p1_if.req || m_last);
          eg1 = p1_if.req && !eg0;
          gp   = eg1;
          gwen = gp ? p1_if.wen   : p0_if.wen;
          ga   = gp ? p1_if.addr  : p0_if.addr;
          gd   = gp ? p1_if.wdata : p0_if.wdata;
          gmask = byte_mask(gp ? p1_if.wstrb : p0_if.wstrb);
          if (eg0 || eg1)
            exp_pins = {eg1, eg0, 1'b0, ~gwen, gwen ? ~gmask : {DW{1'b1}}, ga, gd};
          else
            exp_pins = {2'b00, 1'b1, 1'b1, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}};
          chk("run_pins", act_pins, exp_pins);
          if (eg0 || eg1) begin
            if (gwen) ref_mem[ga] = (ref_mem[ga] & ~gmask) | (gd & gmask);
            else      expq.push_back('{cyc: cyc + 1, port: gp, data: ref_mem[ga]});
            m_last = gp;
          end
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic drive(input bit p, input bit req, input bit wen, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st);
    if (!p) begin
      p0_if.req = req; p0_if.wen = wen; p0_if.addr = a; p0_if.wdata = wd; p0_if.wstrb = st;
    end else begin
      p1_if.req = req; p1_if.wen = wen; p1_if.addr = a; p1_if.wdata = wd; p1_if.wstrb = st;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the grant edge.
  task automatic issue(input bit p, input bit wen, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st);
    bit got;
    got = 1'b0;
    drive(p, 1'b1, wen, a, wd, st);
    for (int t = 0; t < 5000 && !got; t++) begin
      #1;
      got = p ? p1_if.gnt : p0_if.gnt;
      @(negedge clk);
    end
    drive(p, 1'b0, 1'b0, '0, '0, '0);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_wait port=%0d actual=no_grant required=grant", p);
    end
  endtask

  initial begin : stimulus
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    issue(1'b0, 1'b0, 11'd5, '0, '0);
    issue(1'b0, 1'b1, 11'h10, 64'h0123456789ABCDEF, 8'hFF);
    issue(1'b0, 1'b0, 11'h10, '0, '0);
    issue(1'b1, 1'b1, 11'h20, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    issue(1'b1, 1'b0, 11'h20, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 11'd1, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 11'd2, '0, '0);
    repeat (6) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    issue(1'b1, 1'b1, 11'd7, 64'hAA, 8'hFF);
    issue(1'b0, 1'b0, 11'd7, '0, '0);
    for (int i = 0; i < 400; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 31)),
            {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 31)),
            {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 1'b0, 11'd3, '0, '0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (1000) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    issue(1'b1, 1'b0, 11'h10, '0, '0);
    issue(1'b0, 1'b0, 11'd7, '0, '0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
